// File: rtl/rsa_defs.sv
// Shared RSA datapath definitions: default operand width, Montgomery multiplier
// state encodings and the command wrapper's opcodes.
package rsa_defs;

    localparam int RSA_WIDTH = 1024;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOOP = 2'd1,
        ST_SUB  = 2'd2,
        ST_DONE = 2'd3
    } montState_e;

    typedef enum logic [1:0] {
        CMD_READ    = 2'd0,
        CMD_COMPUTE = 2'd1,
        CMD_WRITE   = 2'd2
    } wrapperCmd_e;

endpackage

// File: rtl/mont_cond_sub.sv
// Final Montgomery correction: removes one modulus when the accumulator has
// reached it, leaving a fully reduced WIDTH-bit value.
module mont_cond_sub #(
    parameter int WIDTH = 1024
) (
    input  logic [WIDTH+1:0] accum_i,
    input  logic [WIDTH-1:0] modulus_i,
    output logic [WIDTH-1:0] result_o
);
    logic             geMod;
    logic [WIDTH-1:0] diff;

    // Only the low WIDTH bits of the difference are kept, so a WIDTH-bit subtract suffices.
    assign geMod    = accum_i >= {2'b00, modulus_i};
    assign diff     = accum_i[WIDTH-1:0] - modulus_i;
    assign result_o = geMod ? diff : accum_i[WIDTH-1:0];

endmodule

// File: rtl/montgomery_mult.sv
// Radix-2 bit-serial Montgomery multiplier: result = a*b*2^-WIDTH mod m, one
// multiplier bit per clock followed by a single conditional subtract.
module montgomery_mult
    import rsa_defs::*;
#(
    parameter int WIDTH = RSA_WIDTH
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] m,
    output logic [WIDTH-1:0] result,
    output logic             done,
    output logic             busy
);
    localparam int            IW       = $clog2(WIDTH);
    localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);
    localparam logic [IW-1:0] IDX_ONE  = IW'(1);

    montState_e       state_q, state_d;
    logic [WIDTH-1:0] aReg_q, aReg_d;
    logic [WIDTH-1:0] bReg_q, bReg_d;
    logic [WIDTH-1:0] mReg_q, mReg_d;
    logic [WIDTH+1:0] accum_q, accum_d;
    logic [IW-1:0]    bitIdx_q, bitIdx_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;

    logic [WIDTH+2:0] addend;
    logic [WIDTH+2:0] tSum;
    logic [WIDTH+2:0] tRed;
    logic [WIDTH+1:0] loopNext;
    logic [WIDTH-1:0] subResult;
    logic             unusedLsb;

    // Full-width sum; adding the odd modulus when tSum is odd makes tRed even, so the shift loses nothing.
    assign addend    = aReg_q[bitIdx_q] ? {3'b000, bReg_q} : '0;
    assign tSum      = {1'b0, accum_q} + addend;
    assign tRed      = tSum + ({3'b000, mReg_q} & {(WIDTH + 3){tSum[0]}});
    assign loopNext  = tRed[WIDTH+2:1];
    assign unusedLsb = tRed[0];

    mont_cond_sub #(
        .WIDTH(WIDTH)
    ) u_condSub (
        .accum_i  (accum_q),
        .modulus_i(mReg_q),
        .result_o (subResult)
    );

    always_comb begin
        state_d  = state_q;
        aReg_d   = aReg_q;
        bReg_d   = bReg_q;
        mReg_d   = mReg_q;
        accum_d  = accum_q;
        bitIdx_d = bitIdx_q;
        result_d = result_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_LOOP;
                    aReg_d   = a;
                    bReg_d   = b;
                    mReg_d   = m;
                    accum_d  = '0;
                    bitIdx_d = '0;
                end
            end
            ST_LOOP: begin
                accum_d = loopNext;
                if (bitIdx_q == LAST_IDX) begin
                    state_d = ST_SUB;
                end else begin
                    bitIdx_d = bitIdx_q + IDX_ONE;
                end
            end
            ST_SUB: begin
                result_d = subResult;
                state_d  = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        done_d = (state_q == ST_SUB);
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= ST_IDLE;
            aReg_q   <= '0;
            bReg_q   <= '0;
            mReg_q   <= '0;
            accum_q  <= '0;
            bitIdx_q <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            aReg_q   <= aReg_d;
            bReg_q   <= bReg_d;
            mReg_q   <= mReg_d;
            accum_q  <= accum_d;
            bitIdx_q <= bitIdx_d;
            result_q <= result_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

    assign result = result_q;
    assign done   = done_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_montgomery_mult.sv
// Bench for montgomery_mult: an 8-bit and a 1024-bit instance share clock and
// reset; a scoreboard queue matches each done pulse to its expected product.
module tb_montgomery_mult;
    import rsa_defs::*;

    localparam int W8   = 8;
    localparam int WBIG = RSA_WIDTH;

    logic            clk = 1'b0;
    logic            resetn;
    logic            sel;
    logic            startDrv;
    logic [WBIG-1:0] aDrv, bDrv, mDrv;
    logic [W8-1:0]   result8;
    logic            done8, busy8;
    logic [WBIG-1:0] result1024;
    logic            done1024, busy1024;
    logic            selDone, selBusy;
    logic [WBIG-1:0] selResult;
    logic [WBIG-1:0] expQ[$];
    logic [WBIG-1:0] monExp;
    int              total = 0;
    int              bad = 0;
    int              cyc = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    montgomery_mult #(.WIDTH(W8)) dut8 (
        .clk   (clk),
        .resetn(resetn),
        .start (startDrv & ~sel),
        .a     (aDrv[W8-1:0]),
        .b     (bDrv[W8-1:0]),
        .m     (mDrv[W8-1:0]),
        .result(result8),
        .done  (done8),
        .busy  (busy8)
    );

    montgomery_mult #(.WIDTH(WBIG)) dut1024 (
        .clk   (clk),
        .resetn(resetn),
        .start (startDrv & sel),
        .a     (aDrv),
        .b     (bDrv),
        .m     (mDrv),
        .result(result1024),
        .done  (done1024),
        .busy  (busy1024)
    );

    assign selDone   = sel ? done1024 : done8;
    assign selBusy   = sel ? busy1024 : busy8;
    assign selResult = sel ? result1024 : {{(WBIG - W8){1'b0}}, result8};

    task automatic checkOutput(input string tag, input logic [WBIG-1:0] obs, input logic [WBIG-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0h required=%0h (low 128 bits)", tag, obs[127:0], exp[127:0]);
        end
    endtask

    // Reference for WIDTH=8: the unique r < m with r*2^8 == a*b (mod m), found by search.
    function automatic int refMont8(int aV, int bV, int mV);
        int found;
        found = -1;
        for (int r = 0; r < mV; r++) begin
            if (found < 0 && ((r * 256) % mV) == ((aV * bV) % mV)) found = r;
        end
        return found;
    endfunction

    // For m = 13 and WIDTH = 1024, 2^1024 == 3 (mod 13) whose inverse is 9.
    function automatic int refMont13Big(int aV, int bV);
        return (aV * bV * 9) % 13;
    endfunction

    // Scoreboard: every done pulse pops one expectation and checks the held result.
    always @(negedge clk) begin
        if (resetn === 1'b1 && selDone === 1'b1) begin
            if (expQ.size() > 0) begin
                monExp = expQ.pop_front();
                checkOutput("scoreboard result", selResult, monExp);
            end else begin
                checkOutput("scoreboard spurious done", 1024'(expQ.size()), 1024'd1);
            end
        end
    end

    // One operation with no cycle-level checks beyond a bounded wait for done.
    task automatic applyStimulus(input logic [WBIG-1:0] aV, input logic [WBIG-1:0] bV,
                                 input logic [WBIG-1:0] mV, input logic [WBIG-1:0] expV,
                                 input bit scramble, input string tag);
        int w;
        bit seen;
        w = sel ? WBIG : W8;
        @(negedge clk);
        aDrv = aV; bDrv = bV; mDrv = mV; startDrv = 1'b1;
        expQ.push_back(expV);
        @(posedge clk);
        #1 startDrv = 1'b0;
        if (scramble) begin
            aDrv = '1; bDrv = 1024'd5; mDrv = 1024'd9;
        end
        seen = 1'b0;
        for (int k = 0; k < w + 10 && !seen; k++) begin
            @(negedge clk);
            if (selDone === 1'b1) seen = 1'b1;
        end
        checkOutput({tag, " done seen"}, 1024'(seen), 1024'd1);
    endtask

    // One operation with done latency, busy window and result hold checked every cycle.
    task automatic runTimed(input logic [WBIG-1:0] aV, input logic [WBIG-1:0] bV,
                            input logic [WBIG-1:0] mV, input logic [WBIG-1:0] expV,
                            input bit noisy, input string tag);
        int w, doneAt, doneCnt, busyErr;
        w = sel ? WBIG : W8;
        doneAt = -1; doneCnt = 0; busyErr = 0;
        @(negedge clk);
        aDrv = aV; bDrv = bV; mDrv = mV; startDrv = 1'b1;
        expQ.push_back(expV);
        @(posedge clk);
        #1 startDrv = 1'b0;
        for (int k = 0; k <= w + 4; k++) begin
            @(negedge clk);
            if (selDone === 1'b1) begin
                doneCnt++;
                doneAt = k;
            end
            if (selBusy !== (k <= w + 1)) busyErr++;
            if (k == w + 3) checkOutput({tag, " result held"}, selResult, expV);
            startDrv = noisy && (k == 3 || k == w + 1);
            if (startDrv) begin
                aDrv = 1024'($urandom_range(12, 1)); bDrv = 1024'($urandom_range(12, 1)); mDrv = 1024'd11;
            end
        end
        startDrv = 1'b0;
        checkOutput({tag, " done count"}, 1024'(doneCnt), 1024'd1);
        checkOutput({tag, " done cycle"}, 1024'(doneAt), 1024'(w + 1));
        checkOutput({tag, " busy window errors"}, 1024'(busyErr), 1024'd0);
    endtask

    initial begin
        logic [WBIG-1:0] allOnes;
        int nDone, lateDones;
        int doneCyc[3];

        resetn = 1'b0; sel = 1'b0; startDrv = 1'b0;
        aDrv = '0; bDrv = '0; mDrv = '0;
        allOnes = '1;
        $display("[TB] wrapper codes READ=%0d COMPUTE=%0d WRITE=%0d", CMD_READ, CMD_COMPUTE, CMD_WRITE);

        repeat (3) @(negedge clk);
        checkOutput("reset result8", 1024'(result8), '0);
        checkOutput("reset done8", 1024'(done8), '0);
        checkOutput("reset busy8", 1024'(busy8), '0);
        checkOutput("reset result1024", result1024, '0);
        checkOutput("reset done1024", 1024'(done1024), '0);
        checkOutput("reset busy1024", 1024'(busy1024), '0);
        resetn = 1'b1;

        // 8-bit instance: latency, ignored start pulses, input changes after acceptance.
        runTimed(1024'd5, 1024'd7, 1024'd13, 1024'd1, 1'b0, "w8 5*7");
        runTimed(1024'd6, 1024'd11, 1024'd13, 1024'(refMont8(6, 11, 13)), 1'b1, "w8 noisy start");
        applyStimulus(1024'd3, 1024'd4, 1024'd13, 1024'(refMont8(3, 4, 13)), 1'b1, "w8 scrambled inputs");

        // Start held high: three operations spaced WIDTH+3 cycles apart.
        doneCyc = '{0, 0, 0};
        nDone = 0;
        @(negedge clk);
        aDrv = 1024'd9; bDrv = 1024'd10; mDrv = 1024'd13; startDrv = 1'b1;
        repeat (3) expQ.push_back(1024'(refMont8(9, 10, 13)));
        for (int k = 0; k < 60 && nDone < 3; k++) begin
            @(negedge clk);
            if (done8 === 1'b1) begin
                doneCyc[nDone] = cyc;
                nDone++;
            end
        end
        startDrv = 1'b0;
        checkOutput("b2b done count", 1024'(nDone), 1024'd3);
        checkOutput("b2b period 1", 1024'(doneCyc[1] - doneCyc[0]), 1024'(W8 + 3));
        checkOutput("b2b period 2", 1024'(doneCyc[2] - doneCyc[1]), 1024'(W8 + 3));

        for (int ai = 0; ai < 13; ai++) begin
            for (int bi = 0; bi < 13; bi++) begin
                applyStimulus(1024'(ai), 1024'(bi), 1024'd13, 1024'(refMont8(ai, bi, 13)), 1'b0, "w8 sweep");
            end
        end

        // 1024-bit instance.
        @(negedge clk);
        sel = 1'b1;
        runTimed(1024'd5, 1024'd7, 1024'd13, 1024'd3, 1'b0, "w1024 5*7");
        applyStimulus(1024'd2, 1024'd3, allOnes, 1024'd6, 1'b0, "w1024 R=1 2*3");
        applyStimulus(allOnes - 1'b1, allOnes - 1'b1, allOnes, 1024'd1, 1'b0, "w1024 R=1 (m-1)^2");
        runTimed(1024'd0, 1024'd12, 1024'd13, 1024'd0, 1'b1, "w1024 0*12 noisy");
        applyStimulus(1024'd1, 1024'd1, 1024'd13, 1024'd9, 1'b0, "w1024 1*1");

        // Abort at iteration 500 with an asynchronous reset.
        @(negedge clk);
        aDrv = 1024'd4; bDrv = 1024'd6; mDrv = 1024'd13; startDrv = 1'b1;
        @(posedge clk);
        #1 startDrv = 1'b0;
        repeat (500) @(posedge clk);
        #2;
        checkOutput("abort busy before reset", 1024'(busy1024), 1024'd1);
        resetn = 1'b0;
        #1;
        checkOutput("abort done", 1024'(done1024), '0);
        checkOutput("abort busy", 1024'(busy1024), '0);
        checkOutput("abort result", result1024, '0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        lateDones = 0;
        for (int k = 0; k < WBIG + 20; k++) begin
            @(negedge clk);
            if (done1024 === 1'b1) lateDones++;
        end
        checkOutput("abort no late done", 1024'(lateDones), '0);

        runTimed(1024'd7, 1024'd9, 1024'd13, 1024'(refMont13Big(7, 9)), 1'b0, "w1024 post-reset");

        checkOutput("scoreboard drained", 1024'(expQ.size()), '0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
